// File: rtl/uart_rx_if.sv
// Bus bundle for the UART receiver: serial line and per-frame configuration in,
// received word and one-cycle status pulses out.
interface uart_rx_if #(parameter int DWIDTH = 8);
   logic              rx_in;
   logic [5:0]        prescale;
   logic              parity_en;
   logic              parity_type;
   logic [DWIDTH-1:0] p_data;
   logic              data_valid;
   logic              parity_error;
   logic              stop_error;

   modport master (output rx_in, prescale, parity_en, parity_type,
                   input  p_data, data_valid, parity_error, stop_error);
   modport slave  (input  rx_in, prescale, parity_en, parity_type,
                   output p_data, data_valid, parity_error, stop_error);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// optional even/odd parity, one stop bit, one-cycle result/status pulses.
module uart_rx #(parameter int DWIDTH = 8) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            r_state;
   logic              r_sync1, r_sync2, r_rxPrev;
   logic [5:0]        r_cnt, r_pres;
   logic              r_parEn, r_parType, r_parErr;
   logic              r_s0, r_s1;
   logic [BW-1:0]     r_bitCnt;
   logic [DWIDTH-1:0] r_shift, r_pData;
   logic              r_dataValid, r_parityError, r_stopError;

   logic              w_rxS, w_fall, w_maj;
   logic              w_sampA, w_sampB, w_decide, w_wrap;
   logic [5:0]        w_half;
   logic [DWIDTH:0]   w_shiftNext;

   assign w_rxS       = r_sync2;
   assign w_fall      = r_rxPrev & ~w_rxS;
   assign w_half      = {1'b0, r_pres[5:1]};
   assign w_sampA     = (r_cnt == w_half - 6'd1);
   assign w_sampB     = (r_cnt == w_half);
   assign w_decide    = (r_cnt == w_half + 6'd1);
   assign w_wrap      = (r_cnt == r_pres - 6'd1);
   assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rxS) | (r_s1 & w_rxS);
   assign w_shiftNext = {w_maj, r_shift};

   assign bus.p_data       = r_pData;
   assign bus.data_valid   = r_dataValid;
   assign bus.parity_error = r_parityError;
   assign bus.stop_error   = r_stopError;

   // r_rxPrev gives the falling-edge detector, so a line stuck low never re-triggers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_sync1  <= bus.rx_in;
         r_sync2  <= r_sync1;
         r_rxPrev <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_cnt         <= 6'd0;
         r_pres        <= 6'd0;
         r_parEn       <= 1'b0;
         r_parType     <= 1'b0;
         r_parErr      <= 1'b0;
         r_s0          <= 1'b0;
         r_s1          <= 1'b0;
         r_bitCnt      <= '0;
         r_shift       <= '0;
         r_pData       <= '0;
         r_dataValid   <= 1'b0;
         r_parityError <= 1'b0;
         r_stopError   <= 1'b0;
      end else begin
         r_dataValid   <= 1'b0;
         r_parityError <= 1'b0;
         r_stopError   <= 1'b0;
         if (r_state != IDLE) begin
            r_cnt <= w_wrap ? 6'd0 : r_cnt + 6'd1;
            if (w_sampA) r_s0 <= w_rxS;
            if (w_sampB) r_s1 <= w_rxS;
         end
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state   <= START;
                  r_cnt     <= 6'd0;
                  r_pres    <= bus.prescale;
                  r_parEn   <= bus.parity_en;
                  r_parType <= bus.parity_type;
                  r_parErr  <= 1'b0;
                  r_bitCnt  <= '0;
               end
            end
            START: begin
               // A start bit that votes high was only a glitch
               if (w_decide && w_maj) begin
                  r_state <= IDLE;
                  r_cnt   <= 6'd0;
               end else if (w_wrap) begin
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_decide) r_shift <= w_shiftNext[DWIDTH:1];
               if (w_wrap) begin
                  if (r_bitCnt == LAST_BIT) r_state <= r_parEn ? PARITY : STOP;
                  else                      r_bitCnt <= r_bitCnt + 1'b1;
               end
            end
            PARITY: begin
               if (w_decide) r_parErr <= (w_maj != ((^r_shift) ^ r_parType));
               if (w_wrap)   r_state  <= STOP;
            end
            STOP: begin
               // Leave mid-stop-bit so a back-to-back start edge is not missed
               if (w_decide) begin
                  r_state       <= IDLE;
                  r_cnt         <= 6'd0;
                  r_stopError   <= ~w_maj;
                  r_parityError <= r_parErr;
                  if (w_maj && !r_parErr) begin
                     r_pData     <= r_shift;
                     r_dataValid <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
